// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits of a WIDTH-bit operation per clock,
// with a registered carry between digits and valid/ready handshakes on both sides.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startValid,
    output logic             startReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             carryIn,
    input  logic             subMode,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow,
    output logic             doneValid,
    input  logic             doneReady
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateE;
    stateE state, stateNext;

    logic [WIDTH-1:0] aReg, bReg, resReg, resNext;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [DIGIT-1:0] dSum;
    logic             dCarry, cIntoTop, lastStep;

    assign {dCarry, dSum} = {1'b0, aReg[DIGIT-1:0]} + {1'b0, bReg[DIGIT-1:0]}
                          + {{DIGIT{1'b0}}, carry};
    // Carry into the digit's top bit falls out of that bit's sum: s ^ a ^ b.
    assign cIntoTop = dSum[DIGIT-1] ^ aReg[DIGIT-1] ^ bReg[DIGIT-1];
    assign lastStep = (state == RUN) && (cnt == CW'(N - 1));

    generate
        if (DIGIT == WIDTH) begin : gFull
            assign resNext = dSum;
        end else begin : gShift
            assign resNext = {dSum, resReg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startValid) stateNext = RUN;
            RUN:     if (lastStep)   stateNext = DONE;
            DONE:    if (doneReady)  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        startReady = (state == IDLE);
        doneValid  = (state == DONE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            aReg     <= '0;
            bReg     <= '0;
            resReg   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && startValid) begin
            aReg   <= inA;
            bReg   <= subMode ? ~inB : inB;
            carry  <= subMode | carryIn;
            cnt    <= '0;
        end else if (state == RUN) begin
            aReg   <= aReg >> DIGIT;
            bReg   <= bReg >> DIGIT;
            resReg <= resNext;
            carry  <= dCarry;
            cnt    <= cnt + 1'b1;
            if (lastStep) begin
                sum      <= resNext;
                carryOut <= dCarry;
                overflow <= cIntoTop ^ dCarry;
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: directed cases on a 16/4 instance plus random sweeps on
// several (WIDTH, DIGIT) instances against an arithmetic reference model.
module tb_digit_serial_adder;
    logic        clk = 1'b0;
    logic        resetN, rstSw;
    logic        startValid, startReady, carryIn, subMode;
    logic [15:0] inA, inB, sum;
    logic        carryOut, overflow, doneValid, doneReady;
    int          nChecks = 0, nPass = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .resetN(resetN), .startValid(startValid), .startReady(startReady),
        .inA(inA), .inB(inB), .carryIn(carryIn), .subMode(subMode), .sum(sum),
        .carryOut(carryOut), .overflow(overflow), .doneValid(doneValid), .doneReady(doneReady)
    );

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on the full-width values.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit cin, input bit sub, output longint unsigned s,
                                  output bit co, output bit ov);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned u;
        longint sa, sb, r, smax, smin;
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        if (sub) begin
            u  = (a - b) & mask;
            co = (a >= b);
            r  = sa - sb;
        end else begin
            u  = a + b + longint'(cin);
            co = ((u >> w) & 1) != 0;
            r  = sa + sb + longint'(cin);
        end
        s  = u & mask;
        ov = (r > smax) || (r < smin);
    endfunction

    task automatic startOp(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub);
        int w = 0;
        while (!startReady && w < 50) begin @(posedge clk); #1; w++; end
        chk("startReadyWait", startReady, 1);
        inA = a; inB = b; carryIn = cin; subMode = sub; startValid = 1'b1;
        @(posedge clk); #1;
        startValid = 1'b0;
        inA = 16'($urandom); inB = 16'($urandom); subMode = ~sub; carryIn = ~cin;
    endtask

    task automatic waitDone(input string tag);
        int lat = 0;
        while (!doneValid && lat < 30) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, lat, 4);
    endtask

    task automatic checkRes(input string tag, input logic [15:0] es, input bit eco, input bit eov);
        chk({tag, " sum"}, sum, es);
        chk({tag, " carryOut"}, carryOut, eco);
        chk({tag, " overflow"}, overflow, eov);
    endtask

    task automatic finishOp;
        doneReady = 1'b1;
        @(posedge clk); #1;
        doneReady = 1'b0;
    endtask

    task automatic fullOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit cin, input bit sub, input logic [15:0] es, input bit eco, input bit eov);
        startOp(a, b, cin, sub);
        waitDone(tag);
        checkRes(tag, es, eco, eov);
        finishOp();
    endtask

    initial begin
        longint unsigned es;
        bit eco, eov, seen;
        logic [15:0] ra, rb;
        bit rc, rs;
        resetN = 1'b0; rstSw = 1'b0; startValid = 1'b0; doneReady = 1'b0;
        inA = '0; inB = '0; carryIn = 1'b0; subMode = 1'b0;
        repeat (3) @(posedge clk);
        #3 resetN = 1'b1; rstSw = 1'b1;
        @(posedge clk); #1;
        chk("rst startReady", startReady, 1);
        chk("rst doneValid", doneValid, 0);
        checkRes("rst", 16'h0000, 0, 0);

        fullOp("add1234", 16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0);
        fullOp("carryChain", 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0);
        fullOp("addOvf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        fullOp("sub5m7", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
        fullOp("subOvf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);

        // Async reset mid-RUN: held result must clear at once, no done follows.
        startOp(16'h1111, 16'h2222, 0, 0);
        @(posedge clk); #3;
        resetN = 1'b0;
        #1;
        chk("midRst doneValid", doneValid, 0);
        checkRes("midRst", 16'h0000, 0, 0);
        #2 resetN = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; seen |= doneValid; end
        chk("midRst noDone", seen, 0);
        chk("midRst startReady", startReady, 1);

        // Stall in DONE with startValid pushing; it must be ignored.
        startOp(16'h00FF, 16'h0101, 0, 0);
        waitDone("stall");
        for (int k = 0; k < 5; k++) begin
            startValid = 1'b1; inA = 16'($urandom); inB = 16'($urandom);
            @(posedge clk); #1;
            chk("stall doneValid", doneValid, 1);
            chk("stall sum", sum, 16'h0200);
            chk("stall startReady", startReady, 0);
        end
        doneReady = 1'b1; inA = 16'h0003; inB = 16'h0004; carryIn = 1'b0; subMode = 1'b0;
        @(posedge clk); #1;
        doneReady = 1'b0;
        chk("release startReady", startReady, 1);
        chk("release doneValid", doneValid, 0);
        @(posedge clk); #1;
        startValid = 1'b0;
        chk("nextAccept startReady", startReady, 0);
        waitDone("afterStall");
        checkRes("afterStall", 16'h0007, 0, 0);
        finishOp();

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            model(16, ra, rb, rc, rs, es, eco, eov);
            fullOp("rand16x4", ra, rb, rc, rs, 16'(es), eco, eov);
        end

        for (int t = 0; t < 80000 && !(sw[0].done && sw[1].done && sw[2].done && sw[3].done); t++)
            @(posedge clk);
        chk("sweepsDone", {sw[0].done, sw[1].done, sw[2].done, sw[3].done}, 4'hF);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W = (g == 2) ? 8 : (g == 3) ? 32 : 16;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 16 : (g == 2) ? 2 : 8;
        localparam int N = W / D;
        logic         sv, sr, cin, sub, dv, dr, co, ov;
        logic [W-1:0] a, b, s;
        bit           done = 1'b0;

        digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dutSw (
            .clk(clk), .resetN(rstSw), .startValid(sv), .startReady(sr),
            .inA(a), .inB(b), .carryIn(cin), .subMode(sub), .sum(s),
            .carryOut(co), .overflow(ov), .doneValid(dv), .doneReady(dr)
        );

        initial begin
            longint unsigned es;
            bit eco, eov;
            int lat, w;
            sv = 1'b0; dr = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            wait (rstSw === 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < 1000; i++) begin
                w = 0;
                while (!sr && w < 50) begin @(posedge clk); #1; w++; end
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                model(W, a, b, cin, sub, es, eco, eov);
                sv = 1'b1;
                @(posedge clk); #1;
                sv = 1'b0; a = W'($urandom); b = W'($urandom); sub = ~sub;
                lat = 0;
                while (!dv && lat < N + 20) begin
                    dr = 1'($urandom_range(0, 1));
                    @(posedge clk); #1; lat++;
                end
                dr = 1'b0;
                chk($sformatf("sw%0d/%0d latency", W, D), lat, N);
                chk($sformatf("sw%0d/%0d sum", W, D), s, es);
                chk($sformatf("sw%0d/%0d carryOut", W, D), co, eco);
                chk($sformatf("sw%0d/%0d overflow", W, D), ov, eov);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                dr = 1'b1;
                @(posedge clk); #1;
                dr = 1'b0;
            end
            done = 1'b1;
        end
    end
endmodule
